sine_sample_gen: RTL and testbench

Upstream sample source for the `Transmission` stage of the sine-wave path. Each sample period it produces one offset-binary sine sample from a phase accumulator and a quarter-wave lookup table, then issues a one-cycle `load` strobe to `Transmission`. It respects a `tx_busy` back-pressure signal from the transmitter and flags any sample lost to overrun.

---
 rtl/sine_sample_gen.sv | 153 +++++++++++++++
 tb/tb_sine_sample_gen.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sine_sample_gen.sv
// sine_sample_gen: phase-accumulator sine source with quarter-wave LUT and load/overrun handshake.
// Optional phase dither via SINE_GEN_DITHER_EN (16-bit LFSR added to the phase entering S1).
module sine_sample_gen #(
    parameter int DATA_WIDTH  = 12,
    parameter int PHASE_WIDTH = 16,
    parameter int LUT_ADDR    = 8,
    parameter int PERIOD      = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [PHASE_WIDTH-1:0] phase_inc,
    input  logic                   tx_busy,
    output logic                   load,
    output logic [DATA_WIDTH-1:0]  sample,
    output logic                   overrun
);

    localparam int CW   = $clog2(PERIOD);
    localparam int NLUT = 1 << LUT_ADDR;
    localparam int QW   = DATA_WIDTH - 1;
    localparam int TW   = LUT_ADDR + 2;
    localparam logic [DATA_WIDTH-1:0] MID    = {1'b1, {QW{1'b0}}};
    localparam logic [CW-1:0]         TC_VAL = CW'(PERIOD - 1);

    // Quarter-wave value at the centre of bin i, evaluated at elaboration
    function automatic logic [QW-1:0] lut_val(input int i);
        real x;
        real t;
        real s;
        x = 2.0 * 3.14159265358979323846 * (real'(i) + 0.5) / real'(4 * NLUT);
        t = x;
        s = x;
        for (int k = 1; k < 12; k++) begin
            t = -t * x * x / real'((2 * k) * (2 * k + 1));
            s = s + t;
        end
        return QW'($rtoi(s * real'((1 << QW) - 1) + 0.5));
    endfunction

    logic [QW-1:0] lut_rom [NLUT];

    for (genvar g = 0; g < NLUT; g++) begin : g_lut
        localparam logic [QW-1:0] V = lut_val(g);
        assign lut_rom[g] = V;
    end

    logic [CW-1:0]          cnt;
    logic [PHASE_WIDTH-1:0] acc;
    logic                   tc;
    logic [TW-1:0]          ph_top;

    logic                   s1_vld;
    logic [1:0]             s1_quad;
    logic [LUT_ADDR-1:0]    s1_idx;
    logic                   s2_vld;
    logic                   s2_neg;
    logic [QW-1:0]          s2_q;
    logic [DATA_WIDTH-1:0]  s3_res;
    logic                   pend;

    assign tc = en && (cnt == TC_VAL);

`ifdef SINE_GEN_DITHER_EN
    localparam int DB = PHASE_WIDTH - LUT_ADDR - 2;
    logic [15:0] lfsr;

    // Only the top phase bits survive; the dithered sum feeds S1 and never the accumulator
    assign ph_top = TW'((acc + PHASE_WIDTH'(lfsr[DB-1:0])) >> DB);

    // LFSR steps once per terminal count, after its bits were consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr <= 16'hACE1;
        else if (tc)
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
`else
    assign ph_top = acc[PHASE_WIDTH-1 -: TW];
`endif

    // Sample-period counter and phase accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            acc <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else if (tc) begin
            cnt <= '0;
            acc <= acc + phase_inc;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // S1 captures quadrant/index, S2 reads the mirrored LUT address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_quad <= '0;
            s1_idx  <= '0;
            s2_vld  <= 1'b0;
            s2_neg  <= 1'b0;
            s2_q    <= '0;
        end else begin
            s1_vld <= tc;
            if (tc) begin
                s1_quad <= ph_top[TW-1 -: 2];
                s1_idx  <= ph_top[LUT_ADDR-1:0];
            end
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_neg <= s1_quad[1];
                s2_q   <= lut_rom[s1_quad[0] ? ~s1_idx : s1_idx];
            end
        end
    end

    // Lower half-wave subtracts from midscale
    always_comb begin
        s3_res = MID + {1'b0, s2_q};
        if (s2_neg)
            s3_res = MID - {1'b0, s2_q};
    end

    // S3 output register with tx_busy hold-off and overrun detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample  <= MID;
            load    <= 1'b0;
            overrun <= 1'b0;
            pend    <= 1'b0;
        end else begin
            load    <= 1'b0;
            overrun <= 1'b0;
            if (s2_vld) begin
                sample  <= s3_res;
                overrun <= pend;
                if (!tx_busy && !load) begin
                    load <= 1'b1;
                    pend <= 1'b0;
                end else begin
                    pend <= 1'b1;
                end
            end else if (pend && !tx_busy) begin
                load <= 1'b1;
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sine_sample_gen.sv
// tb_sine_sample_gen: directed bench for sine_sample_gen with default parameters.
// Expected dither results follow SINE_GEN_DITHER_EN when the bench is built with it.
module tb_sine_sample_gen;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] phase_inc;
    logic        tx_busy;
    logic        load;
    logic [11:0] sample;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    sine_sample_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .phase_inc (phase_inc),
        .tx_busy   (tx_busy),
        .load      (load),
        .sample    (sample),
        .overrun   (overrun)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic wait_load(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (load) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        en      = 1'b0;
        tx_busy = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    // Directed sequence
    initial begin
        int n;
        int nl;
        int no;
        int ocyc;
        int s34;
        int s66;
        int quad_exp [5];

        quad_exp = '{2054, 4095, 2042, 1, 2054};
        rst_n     = 1'b0;
        en        = 1'b0;
        tx_busy   = 1'b0;
        phase_inc = 16'h0000;

        step(3);
        check("rst_sample", int'(sample), 2048);
        check("rst_load", int'(load), 0);
        check("rst_overrun", int'(overrun), 0);

        rst_n = 1'b1;
        nl = 0;
        no = 0;
        for (int c = 0; c < 200; c++) begin
            step(1);
            if (load) nl++;
            if (overrun) no++;
        end
        check("idle_loads", nl, 0);
        check("idle_overruns", no, 0);
        check("idle_sample", int'(sample), 2048);

        phase_inc = 16'h0000;
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_load(40, n);
            check("dc_spacing", n, (k == 0) ? 34 : 32);
            check("dc_sample", int'(sample), 2054);
        end
        step(1);
        check("dc_load_width", int'(load), 0);
        en = 1'b0;

        do_reset();
        phase_inc = 16'h4000;
        en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_load(40, n);
            check("quad_spacing", n, (k == 0) ? 34 : 32);
            check("quad_sample", int'(sample), quad_exp[k]);
        end
        en = 1'b0;

        do_reset();
        phase_inc = 16'h4000;
        tx_busy = 1'b1;
        en = 1'b1;
        nl = 0;
        no = 0;
        ocyc = -1;
        s34 = -1;
        s66 = -1;
        for (int c = 1; c <= 69; c++) begin
            step(1);
            if (load) nl++;
            if (overrun) begin
                no++;
                ocyc = c;
            end
            if (c == 34) s34 = int'(sample);
            if (c == 66) s66 = int'(sample);
        end
        check("bp_no_load", nl, 0);
        check("bp_overrun_count", no, 1);
        check("bp_overrun_cycle", ocyc, 66);
        check("bp_first_sample", s34, 2054);
        check("bp_second_sample", s66, 4095);
        tx_busy = 1'b0;
        wait_load(5, n);
        check("bp_release_delay", n, 1);
        check("bp_release_sample", int'(sample), 4095);
        check("bp_release_overrun", int'(overrun), 0);
        wait_load(40, n);
        check("bp_next_delay", n, 28);
        check("bp_next_sample", int'(sample), 2042);
        en = 1'b0;

        do_reset();
        phase_inc = 16'h4000;
        en = 1'b1;
        step(33);
        rst_n = 1'b0;
        en = 1'b0;
        step(1);
        check("midrst_load", int'(load), 0);
        check("midrst_sample", int'(sample), 2048);
        rst_n = 1'b1;
        en = 1'b1;
        wait_load(40, n);
        check("midrst_first_delay", n, 34);
        check("midrst_first_sample", int'(sample), 2054);
        en = 1'b0;

        do_reset();
        phase_inc = 16'h003F;
        en = 1'b1;
        wait_load(40, n);
        check("dither_delay0", n, 34);
        check("dither_sample0", int'(sample), 2054);
        wait_load(40, n);
        check("dither_delay1", n, 32);
`ifdef SINE_GEN_DITHER_EN
        check("dither_sample1", int'(sample), 2067);
`else
        check("dither_sample1", int'(sample), 2054);
`endif
        en = 1'b0;
        step(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
